// File: rtl/ni_config_pkg.sv
// ni_config_pkg
// Shared definitions for the NI configuration bus: OCP command and
// response encodings, default bus widths and the arbiter FSM states.
package ni_config_pkg;

    localparam int CFG_ADDR_W = 14;
    localparam int CFG_DATA_W = 32;

    // Processor OCP-style command encodings; 2'b11 is decoded as idle.
    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_WR   = 2'b01;
    localparam logic [1:0] CMD_RD   = 2'b10;

    // Processor response encodings.
    localparam logic [1:0] RESP_NULL = 2'b00;
    localparam logic [1:0] RESP_DVA  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_DATA = 2'd1,
        ST_RESP    = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Unsigned counter that sticks at all-ones. Clear has priority over
// increment.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset, count -> 0
//   inc   - count up by one unless already saturated
//   clr   - synchronous clear to 0
//   cnt   - current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/config_bus_arbiter.sv
// config_bus_arbiter
// Shares the NI configuration bus between the RX unit and the local
// processor. RX writes come from a TDM stream that cannot be held off, so
// any cycle with rx_en set belongs to RX. Processor commands are accepted
// only in RX-silent cycles while the FSM is idle and get a one-cycle DVA
// response: one cycle after a write accept, two after a read accept.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   rx_addr/en/wr/wdata        - RX unit config access (always wins)
//   proc_cmd/addr/wdata        - processor command, held until accepted
//   proc_cmd_accept            - combinational accept for this cycle
//   proc_resp, proc_rdata      - response (DVA) and registered read data
//   cfg_addr/en/wr/wdata       - access to config targets
//   cfg_rdata                  - target read data, one cycle after a read
//   proc_stall_cnt             - saturating wait count of current command
module config_bus_arbiter
    import ni_config_pkg::*;
#(
    parameter int ADDR_W  = CFG_ADDR_W,
    parameter int DATA_W  = CFG_DATA_W,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  rx_addr,
    input  logic               rx_en,
    input  logic               rx_wr,
    input  logic [DATA_W-1:0]  rx_wdata,
    input  logic [1:0]         proc_cmd,
    input  logic [ADDR_W-1:0]  proc_addr,
    input  logic [DATA_W-1:0]  proc_wdata,
    output logic               proc_cmd_accept,
    output logic [1:0]         proc_resp,
    output logic [DATA_W-1:0]  proc_rdata,
    output logic [ADDR_W-1:0]  cfg_addr,
    output logic               cfg_en,
    output logic               cfg_wr,
    output logic [DATA_W-1:0]  cfg_wdata,
    input  logic [DATA_W-1:0]  cfg_rdata,
    output logic [STALL_W-1:0] proc_stall_cnt
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [DATA_W-1:0] r_rdata;
    logic              w_proc_req;
    logic              w_accept;
    logic              w_stall_inc;
    logic              w_stall_clr;

    assign w_proc_req = (proc_cmd == CMD_WR) || (proc_cmd == CMD_RD);

    // Gated by reset so a held command is not driven onto the bus while
    // reset is asserted; it is re-accepted in the first cycle after.
    assign w_accept    = w_proc_req && !rx_en && (r_state == ST_IDLE) && !reset;
    assign w_stall_inc = w_proc_req && rx_en && (r_state == ST_IDLE) && !reset;
    assign w_stall_clr = w_accept || !w_proc_req;

    assign proc_cmd_accept = w_accept;

    // Bus mux: RX owns the cycle whenever rx_en is set, even for an ignored
    // RX read, so the processor never gets the bus in such a cycle.
    always_comb begin
        cfg_en    = 1'b0;
        cfg_wr    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        if (rx_en) begin
            cfg_en    = rx_wr;
            cfg_wr    = rx_wr;
            cfg_addr  = rx_addr;
            cfg_wdata = rx_wdata;
        end else if (w_accept) begin
            cfg_en    = 1'b1;
            cfg_wr    = (proc_cmd == CMD_WR);
            cfg_addr  = proc_addr;
            cfg_wdata = proc_wdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (proc_cmd == CMD_RD) ? ST_RD_DATA : ST_RESP;
                end
            end
            ST_RD_DATA: w_state_nxt = ST_RESP;
            ST_RESP:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Target read data belongs to the access of the previous cycle, which
    // in RD_DATA is always the processor read, whatever RX does now.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (r_state == ST_RD_DATA) begin
            r_rdata <= cfg_rdata;
        end
    end

    assign proc_rdata = r_rdata;
    assign proc_resp  = (r_state == ST_RESP) ? RESP_DVA : RESP_NULL;

    sat_counter #(
        .W(STALL_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_inc),
        .clr   (w_stall_clr),
        .cnt   (proc_stall_cnt)
    );

endmodule

// File: tb/tb_config_bus_arbiter.sv
module tb_config_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] rx_addr;
    logic        rx_en;
    logic        rx_wr;
    logic [31:0] rx_wdata;
    logic [1:0]  proc_cmd;
    logic [13:0] proc_addr;
    logic [31:0] proc_wdata;
    logic        proc_cmd_accept;
    logic [1:0]  proc_resp;
    logic [31:0] proc_rdata;
    logic [13:0] cfg_addr;
    logic        cfg_en;
    logic        cfg_wr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic [15:0] proc_stall_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        bit          rd;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    config_bus_arbiter #(
        .ADDR_W(14), .DATA_W(32), .STALL_W(16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_addr         (rx_addr),
        .rx_en           (rx_en),
        .rx_wr           (rx_wr),
        .rx_wdata        (rx_wdata),
        .proc_cmd        (proc_cmd),
        .proc_addr       (proc_addr),
        .proc_wdata      (proc_wdata),
        .proc_cmd_accept (proc_cmd_accept),
        .proc_resp       (proc_resp),
        .proc_rdata      (proc_rdata),
        .cfg_addr        (cfg_addr),
        .cfg_en          (cfg_en),
        .cfg_wr          (cfg_wr),
        .cfg_wdata       (cfg_wdata),
        .cfg_rdata       (cfg_rdata),
        .proc_stall_cnt  (proc_stall_cnt)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Target model: fixed read-only contents, data one cycle after a read.
    function automatic logic [31:0] tgt_word(input logic [13:0] a);
        if (a == 14'h0020) return 32'h12345678;
        if (a == 14'h0050) return 32'hCAFEF00D;
        return {18'h0, a};
    endfunction

    always @(posedge clk) begin
        if (cfg_en && !cfg_wr) cfg_rdata <= tgt_word(cfg_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input bit rd, input logic [31:0] d, input int lat);
        exp_t x;
        x.rd   = rd;
        x.data = d;
        x.due  = cyc + lat;
        q.push_back(x);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every DVA must match the oldest expected response,
    // arrive on its due cycle, and carry the expected read data.
    always @(negedge clk) begin
        if (!reset) begin
            if (proc_resp == 2'b01) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_dva: got DVA expected NULL (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("dva_cycle", cyc, e.due);
                    if (e.rd) chk("rd_data", proc_rdata, e.data);
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL missing_dva: got %0d expected %0d (cycle %0d)", proc_resp, 1, cyc);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        reset      = 1'b1;
        rx_addr    = '0;
        rx_en      = 1'b0;
        rx_wr      = 1'b0;
        rx_wdata   = '0;
        proc_cmd   = 2'b00;
        proc_addr  = '0;
        proc_wdata = '0;
        cfg_rdata  = '0;

        // Reset state
        @(negedge clk);
        chk("rst_resp", proc_resp, 0);
        chk("rst_rdata", proc_rdata, 0);
        chk("rst_stall", proc_stall_cnt, 0);
        chk("rst_cfg_en", cfg_en, 0);
        chk("rst_accept", proc_cmd_accept, 0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // Processor write, RX idle
        proc_cmd = 2'b01; proc_addr = 14'h0010; proc_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("wr_accept", proc_cmd_accept, 1);
        chk("wr_cfg_en", cfg_en, 1);
        chk("wr_cfg_wr", cfg_wr, 1);
        chk("wr_cfg_addr", cfg_addr, 32'h10);
        chk("wr_cfg_wdata", cfg_wdata, 32'hDEADBEEF);
        push(1'b0, 32'h0, 1);
        next_cycle();
        proc_cmd = 2'b00;
        @(negedge clk);
        chk("wr_resp_no_accept", proc_cmd_accept, 0);
        next_cycle();
        next_cycle();

        // Processor read
        proc_cmd = 2'b10; proc_addr = 14'h0020;
        @(negedge clk);
        chk("rd_accept", proc_cmd_accept, 1);
        chk("rd_cfg_en", cfg_en, 1);
        chk("rd_cfg_wr", cfg_wr, 0);
        chk("rd_cfg_addr", cfg_addr, 32'h20);
        push(1'b1, 32'h12345678, 2);
        next_cycle();
        proc_cmd = 2'b00;
        repeat (3) next_cycle();

        // RX write collides with processor write
        proc_cmd = 2'b01; proc_addr = 14'h0040; proc_wdata = 32'h11112222;
        rx_en = 1'b1; rx_wr = 1'b1; rx_addr = 14'h0003; rx_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        chk("col_accept", proc_cmd_accept, 0);
        chk("col_cfg_en", cfg_en, 1);
        chk("col_cfg_wr", cfg_wr, 1);
        chk("col_cfg_addr", cfg_addr, 32'h3);
        chk("col_cfg_wdata", cfg_wdata, 32'hA5A5A5A5);
        next_cycle();
        rx_en = 1'b0; rx_wr = 1'b0;
        @(negedge clk);
        chk("col_stall", proc_stall_cnt, 1);
        chk("col_late_accept", proc_cmd_accept, 1);
        chk("col_late_addr", cfg_addr, 32'h40);
        push(1'b0, 32'h0, 1);
        next_cycle();
        proc_cmd = 2'b00;
        @(negedge clk);
        chk("col_stall_clr", proc_stall_cnt, 0);
        repeat (2) next_cycle();

        // RX write during the RD_DATA cycle of a processor read
        proc_cmd = 2'b10; proc_addr = 14'h0050;
        @(negedge clk);
        chk("rdx_accept", proc_cmd_accept, 1);
        push(1'b1, 32'hCAFEF00D, 2);
        next_cycle();
        proc_cmd = 2'b00;
        rx_en = 1'b1; rx_wr = 1'b1; rx_addr = 14'h0050; rx_wdata = 32'h0BADF00D;
        @(negedge clk);
        chk("rdx_cfg_en", cfg_en, 1);
        chk("rdx_cfg_addr", cfg_addr, 32'h50);
        chk("rdx_cfg_wdata", cfg_wdata, 32'h0BADF00D);
        next_cycle();
        rx_en = 1'b0; rx_wr = 1'b0;
        repeat (3) next_cycle();

        // Back-to-back writes with the command held: accept every 2nd cycle
        proc_cmd = 2'b01; proc_addr = 14'h0060; proc_wdata = 32'h00C0FFEE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_accept", proc_cmd_accept, (i % 2 == 0) ? 1 : 0);
            if (proc_cmd_accept) push(1'b0, 32'h0, 1);
            next_cycle();
        end
        proc_cmd = 2'b00;
        repeat (2) next_cycle();

        // Long RX read burst (ignored by targets) with a read pending
        proc_cmd = 2'b10; proc_addr = 14'h0020;
        rx_en = 1'b1; rx_wr = 1'b0; rx_addr = 14'h0007;
        @(negedge clk);
        chk("sat_cfg_en", cfg_en, 0);
        chk("sat_accept", proc_cmd_accept, 0);
        repeat (70000) @(posedge clk);
        #1;
        rx_en = 1'b0;
        @(negedge clk);
        chk("sat_stall", proc_stall_cnt, 32'hFFFF);
        chk("sat_accept_after", proc_cmd_accept, 1);
        push(1'b1, 32'h12345678, 2);
        next_cycle();
        proc_cmd = 2'b00;
        @(negedge clk);
        chk("sat_stall_clr", proc_stall_cnt, 0);
        repeat (3) next_cycle();

        // Reset during RD_DATA; command held and re-accepted afterwards
        proc_cmd = 2'b10; proc_addr = 14'h0050;
        @(negedge clk);
        chk("abort_accept", proc_cmd_accept, 1);
        next_cycle();
        reset = 1'b1;
        #1;
        chk("abort_resp", proc_resp, 0);
        chk("abort_rdata", proc_rdata, 0);
        chk("abort_no_accept", proc_cmd_accept, 0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("reaccept", proc_cmd_accept, 1);
        push(1'b1, 32'hCAFEF00D, 2);
        next_cycle();
        proc_cmd = 2'b00;
        repeat (4) next_cycle();

        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
